pin_lock_ctrl: RTL and testbench

//  Access-control stage between keypad scanner and UART transmitter in the room terminal.

---
 rtl/pin_lock_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pin_lock_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_lock_ctrl.sv
// pin_lock_ctrl: access-control stage between the keypad scanner and the UART transmitter.
// Collects debounced key digits into a PIN and checks it against a stored code. A match
// releases the door strike for a timed window. Repeated mismatches lock the keypad out.
// Every event is reported to the UART as one ASCII byte through a small event FIFO.
//
// Ports
//   FPGA_CLK1_50  in   system clock
//   reset_n       in   asynchronous active-low reset
//   key_valid     in   1-cycle strobe, key_code valid
//   key_code      in   0-9 digit, A = '*' clear, B = '#' enter, C-F ignored
//   available     in   room-available switch (level)
//   unavailable   in   room-unavailable / DND switch (level, dominates available)
//   tx_busy       in   UART busy, start not accepted
//   TxD_start     out  1-cycle pulse, send TxD_data
//   TxD_data      out  ASCII event byte, held until the next start
//   lock_output   out  1 = strike released
//   LED           out  active-low: [3:0] digits-entered thermometer, [8] locked out
module pin_lock_ctrl #(
    parameter int unsigned PIN_LEN        = 4,
    parameter logic [31:0] PIN_CODE       = 32'h0000_1234,
    parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
    parameter int unsigned ENTRY_TIMEOUT  = 500_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       available,
    input  logic       unavailable,
    input  logic       tx_busy,
    output logic       TxD_start,
    output logic [7:0] TxD_data,
    output logic       lock_output,
    output logic [8:0] LED
);

    localparam int unsigned TMR_MAX_A = (UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > LOCKOUT_CYCLES) ? TMR_MAX_A : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam int unsigned CNT_W     = $clog2(PIN_LEN + 1);
    localparam int unsigned FAIL_W    = $clog2(MAX_FAILS + 1);
    localparam int unsigned FIFO_D    = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned QCNT_W    = 3;
    localparam int unsigned N_EV      = 3;
    localparam logic [31:0] PIN_MASK  = (PIN_LEN >= 8) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << (4 * PIN_LEN)) - 64'd1);

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_ENT = 4'hB;

    localparam logic [7:0] EV_UNLOCK  = 8'h55;  // 'U'
    localparam logic [7:0] EV_FAIL    = 8'h46;  // 'F'
    localparam logic [7:0] EV_LOCKOUT = 8'h4C;  // 'L'
    localparam logic [7:0] EV_NOTAVL  = 8'h4E;  // 'N'
    localparam logic [7:0] EV_TIMEOUT = 8'h54;  // 'T'
    localparam logic [7:0] EV_DND     = 8'h58;  // 'X'
    localparam logic [7:0] EV_AVAIL   = 8'h41;  // 'A'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t              state;
    logic [31:0]         pin_buf;
    logic [CNT_W-1:0]    dig_cnt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;
    logic [1:0]          prev_stat;
    logic [7:0]          q [FIFO_D];
    logic [QCNT_W-1:0]   q_cnt;
    logic [1:0]          hold;

    // Active-low thermometer of how many digits are held.
    function automatic logic [3:0] therm(input logic [CNT_W-1:0] n);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            t[i] = !(int'(n) > i);
        end
        return t;
    endfunction

    // Key decode, check outcome and event generation for this cycle.
    logic              is_digit_c;
    logic              take_digit_c;
    logic              clear_c;
    logic              enter_c;
    logic              timeout_c;
    logic              match_c;
    logic              fail_last_c;
    logic [1:0]        eff_stat_c;
    logic [N_EV-1:0]   ev_v;
    logic [7:0]        ev_b [N_EV];

    always_comb begin
        is_digit_c   = (key_code <= 4'd9);
        take_digit_c = 1'b0;
        clear_c      = 1'b0;
        enter_c      = 1'b0;
        timeout_c    = 1'b0;
        match_c      = (dig_cnt == CNT_W'(PIN_LEN)) && ((pin_buf & PIN_MASK) == (PIN_CODE & PIN_MASK));
        fail_last_c  = ((fail_cnt + FAIL_W'(1)) == FAIL_W'(MAX_FAILS));
        eff_stat_c   = unavailable ? 2'b10 : (available ? 2'b01 : 2'b00);
        ev_v         = '0;
        for (int i = 0; i < N_EV; i++) begin
            ev_b[i] = 8'h00;
        end

        case (state)
            ST_IDLE: take_digit_c = key_valid && is_digit_c;
            ST_ENTRY: begin
                clear_c      = key_valid && (key_code == KEY_CLR);
                enter_c      = key_valid && (key_code == KEY_ENT);
                // Digits past PIN_LEN are dropped and do not restart the idle timer.
                take_digit_c = key_valid && is_digit_c && (dig_cnt < CNT_W'(PIN_LEN));
                timeout_c    = !(clear_c || enter_c || take_digit_c)
                               && (timer == TMR_W'(ENTRY_TIMEOUT - 1));
            end
            default: ;
        endcase

        // Slot order fixes enqueue order: FSM event, lockout, then room status.
        if (state == ST_CHECK) begin
            ev_v[0] = 1'b1;
            ev_b[0] = unavailable ? EV_NOTAVL : (match_c ? EV_UNLOCK : EV_FAIL);
            ev_v[1] = !unavailable && !match_c && fail_last_c;
            ev_b[1] = EV_LOCKOUT;
        end else if (timeout_c) begin
            ev_v[0] = 1'b1;
            ev_b[0] = EV_TIMEOUT;
        end
        ev_v[2] = (eff_stat_c != prev_stat) && (eff_stat_c != 2'b00);
        ev_b[2] = eff_stat_c[1] ? EV_DND : EV_AVAIL;
    end

    // Access-control FSM with registered lock and LED outputs.
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pin_buf     <= '0;
            dig_cnt     <= '0;
            fail_cnt    <= '0;
            timer       <= '0;
            lock_output <= 1'b0;
            LED         <= 9'h1FF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_digit_c) begin
                        pin_buf    <= {28'h0, key_code};
                        dig_cnt    <= CNT_W'(1);
                        timer      <= '0;
                        LED[3:0]   <= therm(CNT_W'(1));
                        state      <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (clear_c || timeout_c) begin
                        pin_buf  <= '0;
                        dig_cnt  <= '0;
                        LED[3:0] <= 4'hF;
                        state    <= ST_IDLE;
                    end else if (enter_c) begin
                        state <= ST_CHECK;
                    end else if (take_digit_c) begin
                        pin_buf  <= {pin_buf[27:0], key_code};
                        dig_cnt  <= dig_cnt + CNT_W'(1);
                        LED[3:0] <= therm(dig_cnt + CNT_W'(1));
                        timer    <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_CHECK: begin
                    pin_buf  <= '0;
                    dig_cnt  <= '0;
                    LED[3:0] <= 4'hF;
                    timer    <= '0;
                    if (unavailable) begin
                        state <= ST_IDLE;
                    end else if (match_c) begin
                        fail_cnt    <= '0;
                        lock_output <= 1'b1;
                        state       <= ST_UNLOCKED;
                    end else if (fail_last_c) begin
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        LED[8]   <= 1'b0;
                        state    <= ST_LOCKOUT;
                    end else begin
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        state    <= ST_IDLE;
                    end
                end
                ST_UNLOCKED: begin
                    if (timer == TMR_W'(UNLOCK_CYCLES - 1)) begin
                        lock_output <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                        fail_cnt <= '0;
                        LED[8]   <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Event FIFO next state: pop the head first, then append this cycle's events while room.
    logic              pop_c;
    logic [7:0]        q_nxt [FIFO_D];
    logic [QCNT_W-1:0] q_cnt_nxt;

    assign pop_c = (q_cnt != '0) && !tx_busy && (hold == 2'd0);

    always_comb begin
        q_nxt     = q;
        q_cnt_nxt = q_cnt;
        if (pop_c) begin
            for (int i = 0; i < FIFO_D - 1; i++) begin
                q_nxt[i] = q[i + 1];
            end
            q_nxt[FIFO_D-1] = 8'h00;
            q_cnt_nxt       = q_cnt - QCNT_W'(1);
        end
        for (int i = 0; i < N_EV; i++) begin
            if (ev_v[i] && (q_cnt_nxt < QCNT_W'(FIFO_D))) begin
                q_nxt[q_cnt_nxt[PTR_W-1:0]] = ev_b[i];
                q_cnt_nxt                   = q_cnt_nxt + QCNT_W'(1);
            end
        end
    end

    // FIFO storage, UART handshake and room-status edge tracking.
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_D; i++) begin
                q[i] <= 8'h00;
            end
            q_cnt     <= '0;
            hold      <= 2'd0;
            prev_stat <= 2'b00;
            TxD_start <= 1'b0;
            TxD_data  <= 8'h00;
        end else begin
            q         <= q_nxt;
            q_cnt     <= q_cnt_nxt;
            prev_stat <= eff_stat_c;
            TxD_start <= pop_c;
            if (pop_c) begin
                TxD_data <= q[0];
            end
            // After a start, wait for the UART to report busy or two cycles to pass.
            if (pop_c) begin
                hold <= 2'd2;
            end else if (tx_busy) begin
                hold <= 2'd0;
            end else if (hold != 2'd0) begin
                hold <= hold - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Testbench for pin_lock_ctrl with scaled timing constants.
module tb_pin_lock_ctrl;

    localparam int UC  = 20;
    localparam int ET  = 50;
    localparam int LC  = 100;
    localparam int PL  = 4;
    localparam int MF  = 3;
    localparam logic [31:0] PIN = 32'h0000_1234;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNLOCKED = 3, M_LOCKOUT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       available = 1'b0;
    logic       unavailable = 1'b0;
    logic       tx_busy = 1'b0;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       lock_output;
    logic [8:0] LED;

    always #5 clk = ~clk;

    pin_lock_ctrl #(
        .PIN_LEN(PL), .PIN_CODE(PIN), .UNLOCK_CYCLES(UC),
        .ENTRY_TIMEOUT(ET), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
    ) dut (
        .FPGA_CLK1_50(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .available(available), .unavailable(unavailable), .tx_busy(tx_busy),
        .TxD_start(TxD_start), .TxD_data(TxD_data), .lock_output(lock_output), .LED(LED)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: digits as a list, timers as absolute deadlines, events as a queue.
    int          m_mode;
    int          m_digits[$];
    longint      cyc;
    longint      m_deadline;
    longint      m_end;
    int          m_fails;
    logic [7:0]  m_q[$];
    logic [7:0]  m_ev[$];
    bit          m_lock;
    bit          m_start;
    logic [7:0]  m_data;
    logic [8:0]  m_led;
    longint      m_last_pop;
    bit          m_busy_seen;
    int          m_pstat;

    function automatic bit pin_ok();
        if (m_digits.size() != PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (m_digits[i] != int'((PIN >> (4 * (PL - 1 - i))) & 32'hF)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_IDLE; m_digits.delete(); cyc = 0; m_deadline = 0; m_end = 0;
            m_fails = 0; m_q.delete(); m_lock = 0; m_start = 0; m_data = 8'h00;
            m_led = 9'h1FF; m_last_pop = -10; m_busy_seen = 0; m_pstat = 0;
        end else begin
            int  code;
            int  s;
            bit  gate;
            code = int'(key_code);
            m_ev.delete();
            case (m_mode)
                M_IDLE: if (key_valid && code <= 9) begin
                    m_digits.delete(); m_digits.push_back(code);
                    m_deadline = cyc + ET; m_mode = M_ENTRY;
                end
                M_ENTRY: begin
                    if (key_valid && code == 10) begin
                        m_digits.delete(); m_mode = M_IDLE;
                    end else if (key_valid && code == 11) begin
                        m_mode = M_CHECK;
                    end else if (key_valid && code <= 9 && m_digits.size() < PL) begin
                        m_digits.push_back(code); m_deadline = cyc + ET;
                    end else if (cyc == m_deadline) begin
                        m_digits.delete(); m_mode = M_IDLE; m_ev.push_back(8'h54);
                    end
                end
                M_CHECK: begin
                    if (unavailable) begin
                        m_ev.push_back(8'h4E); m_mode = M_IDLE;
                    end else if (pin_ok()) begin
                        m_ev.push_back(8'h55); m_fails = 0; m_lock = 1;
                        m_end = cyc + UC; m_mode = M_UNLOCKED;
                    end else begin
                        m_ev.push_back(8'h46); m_fails++;
                        if (m_fails >= MF) begin
                            m_ev.push_back(8'h4C); m_end = cyc + LC; m_mode = M_LOCKOUT;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                    m_digits.delete();
                end
                M_UNLOCKED: if (cyc == m_end) begin m_lock = 0; m_mode = M_IDLE; end
                M_LOCKOUT:  if (cyc == m_end) begin m_fails = 0; m_mode = M_IDLE; end
                default: m_mode = M_IDLE;
            endcase
            s = unavailable ? 2 : (available ? 1 : 0);
            if (s != m_pstat && s != 0) m_ev.push_back(s == 2 ? 8'h58 : 8'h41);
            m_pstat = s;
            gate = m_busy_seen || (cyc - m_last_pop >= 3);
            if (m_q.size() > 0 && !tx_busy && gate) begin
                m_start = 1; m_data = m_q.pop_front(); m_last_pop = cyc; m_busy_seen = 0;
            end else begin
                m_start = 0;
                if (tx_busy) m_busy_seen = 1;
            end
            foreach (m_ev[i]) if (m_q.size() < 4) m_q.push_back(m_ev[i]);
            m_led = 9'h1FF;
            m_led[8] = (m_mode == M_LOCKOUT) ? 1'b0 : 1'b1;
            for (int i = 0; i < 4; i++) m_led[i] = (m_digits.size() > i) ? 1'b0 : 1'b1;
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("lock_output", 32'(lock_output), 32'(m_lock));
            chk("TxD_start", 32'(TxD_start), 32'(m_start));
            chk("TxD_data", 32'(TxD_data), 32'(m_data));
            chk("LED", 32'(LED), 32'(m_led));
        end
    end

    // Byte log and unlock-time counter for the directed scenarios.
    logic [7:0] tx_log[$];
    int         lock_hi = 0;
    always @(negedge clk) begin
        if (reset_n && TxD_start) tx_log.push_back(TxD_data);
        if (reset_n && lock_output) lock_hi++;
    end

    function automatic logic [31:0] log_word();
        logic [31:0] w = 32'h0;
        foreach (tx_log[i]) w = (w << 8) | 32'(tx_log[i]);
        return w;
    endfunction

    task automatic press(input int code);
        @(negedge clk); key_valid = 1'b1; key_code = 4'(code);
        @(negedge clk); key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); key_valid = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 reset_n = 1'b1;
        tx_log.delete(); lock_hi = 0;
    endtask

    task automatic build_attempt(inout int kq[$]);
        int len;
        case ($urandom_range(0, 3))
            0, 1: begin kq.push_back(1); kq.push_back(2); kq.push_back(3); kq.push_back(4); kq.push_back(11); end
            2: begin
                len = $urandom_range(1, 6);
                repeat (len) kq.push_back($urandom_range(0, 9));
                if ($urandom_range(0, 3) == 0) kq.push_back(10);
                kq.push_back(11);
            end
            default: begin
                len = $urandom_range(1, 6);
                repeat (len) kq.push_back($urandom_range(0, 15));
            end
        endcase
    endtask

    initial begin
        int keyq[$];
        int gap;

        // Reset state
        idle(3);
        chk("rst_lock", 32'(lock_output), 32'h0);
        chk("rst_start", 32'(TxD_start), 32'h0);
        chk("rst_data", 32'(TxD_data), 32'h0);
        chk("rst_led", 32'(LED), 32'h1FF);
        #1 reset_n = 1'b1;

        // Correct PIN: lock rises two cycles after '#', held UC cycles, one 'U'
        tx_log.delete(); lock_hi = 0;
        press(1); press(2); press(3); press(4); press(11);
        chk("unlock_n1", 32'(lock_output), 32'h0);
        idle(1);
        chk("unlock_n2", 32'(lock_output), 32'h1);
        idle(40);
        chk("unlock_len", 32'(lock_hi), 32'(UC));
        chk("unlock_nlog", 32'(tx_log.size()), 32'h1);
        chk("unlock_log", log_word(), 32'h55);

        // Three failures -> lockout
        do_reset();
        repeat (3) begin
            press(1); press(2); press(3); press(5); press(11); idle(10);
        end
        chk("lockout_led8", 32'(LED[8]), 32'h0);
        press(1); idle(3);
        chk("lockout_keyign", 32'(LED[3:0]), 32'hF);
        chk("lockout_nlog", 32'(tx_log.size()), 32'h4);
        chk("lockout_log", log_word(), 32'h4646464C);
        idle(110);
        chk("lockout_end_led8", 32'(LED[8]), 32'h1);
        press(1); idle(1);
        chk("after_lockout_digit", 32'(LED[3:0]), 32'hE);

        // Overflow digit dropped, then short PIN fails
        do_reset();
        press(1); press(2); press(3); press(4); press(5); press(11);
        idle(30);
        chk("ovf_len", 32'(lock_hi), 32'(UC));
        press(1); press(2); press(11); idle(10);
        chk("ovf_nlog", 32'(tx_log.size()), 32'h2);
        chk("ovf_log", log_word(), 32'h5546);

        // Clear then mismatch; single key then timeout
        do_reset();
        press(1); press(2); press(10); press(3); press(4); press(11); idle(10);
        press(1); idle(55);
        chk("timeout_led", 32'(LED), 32'h1FF);
        chk("clr_to_nlog", 32'(tx_log.size()), 32'h2);
        chk("clr_to_log", log_word(), 32'h4654);

        // UART busy holds three events, released in order
        do_reset();
        tx_busy = 1'b1;
        available = 1'b1; idle(3);
        unavailable = 1'b1; idle(3);
        press(1); press(11); idle(10);
        chk("busy_nostart", 32'(tx_log.size()), 32'h0);
        tx_busy = 1'b0; idle(15);
        chk("busy_nlog", 32'(tx_log.size()), 32'h3);
        chk("busy_log", log_word(), 32'h41584E);

        // Room unavailable blocks unlock
        available = 1'b0;
        do_reset();
        press(1); press(2); press(3); press(4); press(11); idle(30);
        chk("dnd_nlog", 32'(tx_log.size()), 32'h2);
        chk("dnd_log", log_word(), 32'h584E);
        chk("dnd_lock", 32'(lock_hi), 32'h0);
        unavailable = 1'b0;

        // Reset mid-unlock drops the strike immediately
        do_reset();
        press(1); press(2); press(3); press(4); press(11); idle(5);
        chk("mid_unlock", 32'(lock_output), 32'h1);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_lock", 32'(lock_output), 32'h0);
        @(negedge clk); #1 reset_n = 1'b1;

        // Randomized traffic against the reference
        do_reset();
        gap = 0;
        repeat (6000) begin
            @(negedge clk);
            key_valid = 1'b0;
            tx_busy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 119) == 0) available = ~available;
            if ($urandom_range(0, 199) == 0) unavailable = ~unavailable;
            if (gap > 0) begin
                gap--;
            end else begin
                if (keyq.size() == 0) build_attempt(keyq);
                key_valid = 1'b1;
                key_code = 4'(keyq.pop_front());
                gap = ($urandom_range(0, 24) == 0) ? 55 : $urandom_range(0, 3);
            end
        end
        key_valid = 1'b0;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
